// File: rtl/i2c_reg_sequencer.sv
// Turns one single-byte register read/write request into the ena/busy handshake of an
// I2C byte master: every busy rise is a latched command, the final busy fall ends the transfer.
module i2c_reg_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       op_read,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  output logic       seq_busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       error,
  output logic       m_ena,
  output logic [6:0] m_addr,
  output logic       m_rw,
  output logic [7:0] m_data_wr,
  input  logic       m_busy,
  input  logic [7:0] m_data_rd,
  input  logic       m_ack_error
);

  typedef enum logic [2:0] {IDLE, WAIT_IDLE, PH1, PH2, DRAIN, FINISH} state_t;

  localparam logic             TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_n;
  logic             busy_prev, rise, fall;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             counting, timeout, abort;

  logic             op_q, op_n;
  logic [6:0]       dev_q, dev_n;
  logic [7:0]       reg_q, reg_n, wr_q, wr_n;

  logic             seq_busy_n, done_n, error_n, m_ena_n, m_rw_n;
  logic [7:0]       rd_data_n, m_data_wr_n;
  logic [6:0]       m_addr_n;

  assign rise     = m_busy & ~busy_prev;
  assign fall     = ~m_busy & busy_prev;
  assign counting = state inside {WAIT_IDLE, PH1, PH2, DRAIN};
  // cnt is the number of cycles already spent in the current state
  assign timeout  = TO_EN && counting && (cnt == TO_LAST);

  always_comb begin
    state_n     = state;
    cnt_n       = '0;
    abort       = 1'b0;
    op_n        = op_q;
    dev_n       = dev_q;
    reg_n       = reg_q;
    wr_n        = wr_q;
    seq_busy_n  = seq_busy;
    done_n      = 1'b0;
    rd_data_n   = rd_data;
    error_n     = error;
    m_ena_n     = m_ena;
    m_addr_n    = m_addr;
    m_rw_n      = m_rw;
    m_data_wr_n = m_data_wr;

    case (state)
      IDLE: begin
        if (start) begin
          op_n       = op_read;
          dev_n      = dev_addr;
          reg_n      = reg_addr;
          wr_n       = wr_data;
          seq_busy_n = 1'b1;
          error_n    = 1'b0;
          if (!m_busy) begin
            state_n     = PH1;
            m_ena_n     = 1'b1;
            m_addr_n    = dev_addr;
            m_rw_n      = 1'b0;
            m_data_wr_n = reg_addr;
          end else begin
            state_n = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (!m_busy) begin
          state_n     = PH1;
          m_ena_n     = 1'b1;
          m_addr_n    = dev_q;
          m_rw_n      = 1'b0;
          m_data_wr_n = reg_q;
        end else begin
          abort = timeout;
        end
      end
      PH1: begin
        // master has latched dev+W/reg; queue the second command behind it
        if (rise) begin
          m_rw_n      = op_q;
          m_data_wr_n = op_q ? 8'h00 : wr_q;
          state_n     = PH2;
        end else begin
          abort = timeout;
        end
      end
      PH2: begin
        if (rise) begin
          m_ena_n = 1'b0;
          state_n = DRAIN;
        end else begin
          abort = timeout;
        end
      end
      DRAIN: begin
        if (fall) begin
          if (op_q) rd_data_n = m_data_rd;
          error_n = m_ack_error;
          state_n = FINISH;
        end else begin
          abort = timeout;
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (abort) begin
      m_ena_n = 1'b0;
      error_n = 1'b1;
      state_n = FINISH;
    end

    if (state_n == FINISH && state != FINISH) begin
      done_n     = 1'b1;
      seq_busy_n = 1'b0;
    end

    if (counting && state_n == state) cnt_n = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy_prev <= 1'b0;
      cnt       <= '0;
      op_q      <= 1'b0;
      dev_q     <= '0;
      reg_q     <= '0;
      wr_q      <= '0;
      seq_busy  <= 1'b0;
      done      <= 1'b0;
      rd_data   <= '0;
      error     <= 1'b0;
      m_ena     <= 1'b0;
      m_addr    <= '0;
      m_rw      <= 1'b0;
      m_data_wr <= '0;
    end else begin
      state     <= state_n;
      busy_prev <= m_busy;
      cnt       <= cnt_n;
      op_q      <= op_n;
      dev_q     <= dev_n;
      reg_q     <= reg_n;
      wr_q      <= wr_n;
      seq_busy  <= seq_busy_n;
      done      <= done_n;
      rd_data   <= rd_data_n;
      error     <= error_n;
      m_ena     <= m_ena_n;
      m_addr    <= m_addr_n;
      m_rw      <= m_rw_n;
      m_data_wr <= m_data_wr_n;
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer with a behavioural ena/busy byte-master model
// that logs the bus as START/RSTART/STOP markers and byte values.
module tb_i2c_reg_sequencer;

  localparam int TO       = 100;
  localparam int BYTE_CYC = 8;
  localparam logic [9:0] B_S  = 10'h100;
  localparam logic [9:0] B_SR = 10'h101;
  localparam logic [9:0] B_P  = 10'h102;

  typedef logic [7:0][9:0] bus_t;

  typedef struct {
    logic       rd;
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] wd;
    logic [7:0] slv;
    logic       nack;
    logic       exp_err;
    logic [7:0] exp_rd;
    int         exp_len;
    bus_t       exp_bus;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, start, op_read;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr, wr_data;
  logic       seq_busy, done, error, m_ena, m_rw;
  logic [7:0] rd_data, m_data_wr, m_data_rd;
  logic [6:0] m_addr;
  logic       m_busy, m_ack_error;

  logic       mdl_busy = 1'b0, force_busy = 1'b0, model_en = 1'b1, mdl_active = 1'b0;
  logic       mdl_nack = 1'b0;
  logic [7:0] mdl_rd_byte = 8'h00;
  logic [9:0] bus_q[$];

  int checks = 0, failures = 0, done_cnt = 0;

  assign m_busy = mdl_busy | force_busy;

  always #5 clk = ~clk;

  i2c_reg_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .op_read(op_read),
    .dev_addr(dev_addr), .reg_addr(reg_addr), .wr_data(wr_data),
    .seq_busy(seq_busy), .done(done), .rd_data(rd_data), .error(error),
    .m_ena(m_ena), .m_addr(m_addr), .m_rw(m_rw), .m_data_wr(m_data_wr),
    .m_busy(m_busy), .m_data_rd(m_data_rd), .m_ack_error(m_ack_error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_bus(input string name, input bus_t act, input bus_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bus_t mkbus(input logic [9:0] b0, b1, b2, b3, b4, b5, b6);
    bus_t p;
    p = '0;
    p[0] = b0; p[1] = b1; p[2] = b2; p[3] = b3; p[4] = b4; p[5] = b5; p[6] = b6;
    return p;
  endfunction

  function automatic bus_t pack_bus();
    bus_t p;
    p = '0;
    for (int i = 0; i < bus_q.size() && i < 8; i++) p[i] = bus_q[i];
    return p;
  endfunction

  // Byte master: a command is latched two cycles after ena, each byte takes BYTE_CYC,
  // busy dips for one cycle between chained commands, and STOP keeps busy high a bit longer.
  task automatic mdl_txn();
    logic [6:0] a;
    logic       rw;
    logic [7:0] d;
    mdl_active = 1'b1;
    repeat (2) @(negedge clk);
    a = m_addr; rw = m_rw; d = m_data_wr;
    mdl_busy    = 1'b1;
    m_ack_error = 1'b0;
    bus_q.push_back(B_S);
    bus_q.push_back({2'b00, a, rw});
    bus_q.push_back({2'b00, d});
    forever begin
      repeat (BYTE_CYC) @(negedge clk);
      if (!m_ena) break;
      mdl_busy = 1'b0;
      @(negedge clk);
      if (m_addr != a || m_rw != rw) begin
        bus_q.push_back(B_SR);
        bus_q.push_back({2'b00, m_addr, m_rw});
      end
      a = m_addr; rw = m_rw; d = m_data_wr;
      bus_q.push_back(rw ? (10'h200 | {2'b00, mdl_rd_byte}) : {2'b00, d});
      mdl_busy = 1'b1;
    end
    bus_q.push_back(B_P);
    repeat (3) @(negedge clk);
    m_data_rd   = mdl_rd_byte;
    m_ack_error = mdl_nack;
    mdl_busy    = 1'b0;
    mdl_active  = 1'b0;
  endtask

  initial begin
    m_data_rd   = 8'h00;
    m_ack_error = 1'b0;
    forever begin
      @(negedge clk);
      if (model_en && m_ena && !reset) mdl_txn();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic run_txn(input logic rd, input logic [6:0] dv, input logic [7:0] rg, wd, slv,
                         input logic nk);
    int n;
    bus_q.delete();
    mdl_rd_byte = slv;
    mdl_nack    = nk;
    start = 1'b1; op_read = rd; dev_addr = dv; reg_addr = rg; wr_data = wd;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  vec_t vt[6];

  initial begin
    int n, d0;
    logic ena_seen;

    vt[0] = '{1'b0, 7'h3C, 8'h10, 8'hA5, 8'h00, 1'b0, 1'b0, 8'h00, 5,
              mkbus(B_S, 10'h078, 10'h010, 10'h0A5, B_P, 10'h0, 10'h0)};
    vt[1] = '{1'b1, 7'h50, 8'h02, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h5A, 7,
              mkbus(B_S, 10'h0A0, 10'h002, B_SR, 10'h0A1, 10'h25A, B_P)};
    vt[2] = '{1'b0, 7'h22, 8'h33, 8'h44, 8'h00, 1'b1, 1'b1, 8'h5A, 5,
              mkbus(B_S, 10'h044, 10'h033, 10'h044, B_P, 10'h0, 10'h0)};
    vt[3] = '{1'b0, 7'h3C, 8'h11, 8'h0F, 8'h00, 1'b0, 1'b0, 8'h5A, 5,
              mkbus(B_S, 10'h078, 10'h011, 10'h00F, B_P, 10'h0, 10'h0)};
    vt[4] = '{1'b1, 7'h68, 8'h75, 8'h00, 8'hC3, 1'b0, 1'b0, 8'hC3, 7,
              mkbus(B_S, 10'h0D0, 10'h075, B_SR, 10'h0D1, 10'h2C3, B_P)};
    vt[5] = '{1'b1, 7'h11, 8'h40, 8'h00, 8'hFF, 1'b1, 1'b1, 8'hFF, 7,
              mkbus(B_S, 10'h022, 10'h040, B_SR, 10'h023, 10'h2FF, B_P)};

    reset = 1'b1; start = 1'b0; op_read = 1'b0;
    dev_addr = '0; reg_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 32'({seq_busy, done, error, m_ena, m_rw}), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_master_bus", 32'({m_addr, m_data_wr}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      run_txn(vt[i].rd, vt[i].dev, vt[i].rg, vt[i].wd, vt[i].slv, vt[i].nack);
      chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
      chk($sformatf("v%0d_error", i), 32'(error), 32'(vt[i].exp_err));
      chk($sformatf("v%0d_rd_data", i), 32'(rd_data), 32'(vt[i].exp_rd));
      chk($sformatf("v%0d_seq_busy", i), 32'(seq_busy), 32'd0);
      repeat (6) @(negedge clk);
      chk($sformatf("v%0d_done_count", i), 32'(done_cnt - d0), 32'd1);
      chk($sformatf("v%0d_bus_len", i), 32'(bus_q.size()), 32'(vt[i].exp_len));
      chk_bus($sformatf("v%0d_bus", i), pack_bus(), vt[i].exp_bus);
      chk($sformatf("v%0d_error_hold", i), 32'(error), 32'(vt[i].exp_err));
    end

    // start while the master is still busy, plus a second start that must be ignored
    bus_q.delete();
    mdl_nack = 1'b0;
    force_busy = 1'b1;
    d0 = done_cnt;
    ena_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; op_read = 1'b0; dev_addr = 7'h3C; reg_addr = 8'h20; wr_data = 8'h5E;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      if (m_ena) ena_seen = 1'b1;
      @(negedge clk);
    end
    start = 1'b1; op_read = 1'b1; dev_addr = 7'h11; reg_addr = 8'h99; wr_data = 8'h77;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      if (m_ena) ena_seen = 1'b1;
      @(negedge clk);
    end
    chk("wb_ena_held_low", 32'(ena_seen), 32'd0);
    chk("wb_seq_busy", 32'(seq_busy), 32'd1);
    force_busy = 1'b0;
    n = 0;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("wb_done", 32'(done), 32'd1);
    chk("wb_error", 32'(error), 32'd0);
    repeat (30) @(negedge clk);
    chk("wb_done_count", 32'(done_cnt - d0), 32'd1);
    chk("wb_bus_len", 32'(bus_q.size()), 32'd5);
    chk_bus("wb_bus", pack_bus(), mkbus(B_S, 10'h078, 10'h020, 10'h05E, B_P, 10'h0, 10'h0));

    // master stuck busy: timeout out of WAIT_IDLE
    force_busy = 1'b1;
    @(negedge clk);
    start = 1'b1; op_read = 1'b1; dev_addr = 7'h50; reg_addr = 8'h02;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("to_wait_cycles", 32'(n), 32'd100);
    chk("to_wait_error", 32'(error), 32'd1);
    chk("to_wait_ena", 32'(m_ena), 32'd0);
    chk("to_wait_rd_data", 32'(rd_data), 32'hFF);
    force_busy = 1'b0;
    repeat (3) @(negedge clk);

    // master never answers ena: timeout out of PH1
    model_en = 1'b0;
    start = 1'b1; op_read = 1'b0; dev_addr = 7'h3C; reg_addr = 8'h01; wr_data = 8'h02;
    @(negedge clk);
    start = 1'b0;
    chk("to_ph1_ena_on", 32'(m_ena), 32'd1);
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("to_ph1_cycles", 32'(n), 32'd100);
    chk("to_ph1_error", 32'(error), 32'd1);
    chk("to_ph1_ena_off", 32'(m_ena), 32'd0);
    repeat (5) @(negedge clk);
    chk("to_ph1_ena_stays_off", 32'({m_ena, seq_busy}), 32'd0);
    model_en = 1'b1;
    @(negedge clk);

    // reset in PH2 of a read, then a clean read
    bus_q.delete();
    mdl_rd_byte = 8'h3D;
    mdl_nack = 1'b0;
    d0 = done_cnt;
    start = 1'b1; op_read = 1'b1; dev_addr = 7'h50; reg_addr = 8'h02;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(m_ena && m_rw) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_ph2_reached", 32'(m_ena & m_rw), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ph2_outputs", 32'({m_ena, seq_busy, done}), 32'd0);
    chk("rst_ph2_rd_data", 32'(rd_data), 32'd0);
    n = 0;
    while (mdl_active && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("rst_ph2_no_done", 32'(done_cnt - d0), 32'd0);

    d0 = done_cnt;
    run_txn(1'b1, 7'h50, 8'h02, 8'h00, 8'h5A, 1'b0);
    chk("post_rst_done", 32'(done), 32'd1);
    chk("post_rst_rd_data", 32'(rd_data), 32'h5A);
    chk("post_rst_error", 32'(error), 32'd0);
    repeat (6) @(negedge clk);
    chk("post_rst_done_count", 32'(done_cnt - d0), 32'd1);
    chk_bus("post_rst_bus", pack_bus(),
            mkbus(B_S, 10'h0A0, 10'h002, B_SR, 10'h0A1, 10'h25A, B_P));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_reg_sequencer.md
Name: i2c_reg_sequencer

Overview:
- Command sequencer that sits directly upstream of the I2C byte master. It turns one single-byte register request into the master's ena/busy byte handshake.
- Register write: START, dev+W, reg, data, STOP.
- Register read: START, dev+W, reg, repeated START, dev+R, data (NACK), STOP.
- Returns the read byte, a done pulse and error status to the host logic (config ROM walker, CPU bridge).

Parameters:
- TIMEOUT_CYCLES, 2000000: max clk cycles the master busy may stay high in one phase before abort; 0 disables the timeout.
- CNT_W, 32: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request strobe; sampled only in IDLE
- op_read  in  1  1 = register read, 0 = register write
- dev_addr  in  7  7-bit slave address
- reg_addr  in  8  register pointer byte
- wr_data  in  8  data byte for writes
- seq_busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the transaction ends
- rd_data  out  8  captured read byte; held until the next read completes
- error  out  1  valid with done: slave NACK or timeout
- m_ena  out  1  to master ena
- m_addr  out  7  to master addr
- m_rw  out  1  to master rw
- m_data_wr  out  8  to master data_wr
- m_busy  in  1  from master busy
- m_data_rd  in  8  from master data_rd
- m_ack_error  in  1  from master ack_error

Behaviour:
- Reset, synchronous on clk when reset=1:
  - outputs: seq_busy=0, done=0, rd_data=0, error=0, m_ena=0, m_addr=0, m_rw=0, m_data_wr=0.
  - internal: state=IDLE, busy_prev=0, timeout counter=0.
  - A reset mid-transaction drops m_ena immediately and abandons the transfer. No done pulse is issued.
- Edge detect: busy_prev registers m_busy every cycle.
  - rise = m_busy & ~busy_prev
  - fall = ~m_busy & busy_prev
- States:
  - IDLE:
    - start=1 latches op_read, dev_addr, reg_addr, wr_data and sets seq_busy=1.
    - If m_busy=0, go to PH1. Otherwise go to WAIT_IDLE.
    - start while seq_busy=1 is ignored.
  - WAIT_IDLE: wait for m_busy=0, then go to PH1.
  - PH1:
    - Drive m_ena=1, m_addr=dev, m_rw=0, m_data_wr=reg_addr.
    - On rise, the master has latched the command. In the same cycle load phase-2 values:
      - write: m_rw=0, m_data_wr=wr_data
      - read: m_rw=1, m_data_wr=don't care (0)
    - Then go to PH2.
  - PH2:
    - Keep m_ena=1 and wait for the next rise (master accepted byte 2, or a repeated start for a read).
    - On that rise, set m_ena=0 and go to DRAIN.
  - DRAIN: wait for fall.
    - If op=read: rd_data <= m_data_rd in the same cycle.
    - error <= m_ack_error. Go to FINISH.
  - FINISH: done=1 for exactly one cycle, seq_busy=0, return to IDLE. error holds until the next accepted start clears it.
- Timeout:
  - The counter clears on every state change and counts while in WAIT_IDLE, PH1, PH2 or DRAIN.
  - When it reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES>0): m_ena=0, error=1, go to FINISH. rd_data is not updated.
- Simultaneous events:
  - reset has priority over everything.
  - rise and timeout in the same cycle: rise wins.
  - A second rise while in DRAIN is ignored.
- m_addr, m_rw and m_data_wr are stable whenever m_ena=1, except for the registered update on the PH1 rise cycle.
- Latency: done is 1 cycle after the master busy fall that ends the STOP phase.

Test Plan:
- Write dev=0x3C, reg=0x10, data=0xA5 with an ACKing slave model:
  - the bus shows 0x78, 0x10, 0xA5 then STOP
  - one done pulse, error=0, seq_busy low after done.
- Read dev=0x50, reg=0x02, slave returns 0x5A:
  - the bus shows 0xA0, 0x02, repeated START, 0xA1, byte with master NACK, then STOP
  - rd_data=0x5A, error=0.
- Write to an absent slave (all NACK): done pulses once with error=1 and rd_data unchanged. The next good write clears error to 0.
- Master model holds m_busy high with TIMEOUT_CYCLES=100:
  - error=1 and done exactly 100 cycles after entering the stalled state
  - m_ena=0 from that point.
- start pulsed while the master is already busy: m_ena stays 0 until m_busy=0, then the sequence proceeds normally. A second start during seq_busy is ignored (exactly one done).
- reset asserted during PH2 of a read: the next cycle shows m_ena=0, seq_busy=0, no done. A fresh read after reset completes correctly.
